// File: rtl/motor_control_pkg.sv
// Shared state encoding and saturating clamp helpers for motor_control_nch.
package motor_control_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  function automatic int sclamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int uclamp(input int v, input int width);
    return sclamp(v, 0, (1 << width) - 1);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: slew-limited RPM setpoint plus saturating duty accumulator.
// Slew limiting is active only when MOTOR_CONTROL_RAMP_EN is defined.
module motor_channel
  import motor_control_pkg::*;
#(
  parameter int PWM_RESOLUTION = 16,
  parameter int RPM_RESOLUTION = 10,
  parameter int MAX_RPM_OFFSET = 50,
  parameter int MAX_RPM        = 2**RPM_RESOLUTION - 1,
  parameter int RAMP_STEP      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             clear,
  input  logic                             run,
  input  logic        [RPM_RESOLUTION-1:0] base_rpm,
  input  logic signed [RPM_RESOLUTION:0]   rpm_offset,
  input  logic signed [PWM_RESOLUTION:0]   duty_offset,
  output logic        [RPM_RESOLUTION-1:0] setpoint_next,
  output logic        [RPM_RESOLUTION-1:0] setpoint,
  output logic        [PWM_RESOLUTION-1:0] duty,
  output logic                             duty_sat
);

`ifdef MOTOR_CONTROL_RAMP_EN
  localparam int STEP = RAMP_STEP;
`else
  // A step at least MAX_RPM reaches any target in a single tick.
  localparam int STEP = (RAMP_STEP > MAX_RPM) ? RAMP_STEP : MAX_RPM;
`endif

  int target;
  int delta;
  int sp_i;
  int duty_sum;
  int duty_clamped;

  always_comb begin
    target = run ? sclamp(int'(base_rpm) +
                          sclamp(int'(rpm_offset), -MAX_RPM_OFFSET, MAX_RPM_OFFSET),
                          0, MAX_RPM)
                 : 0;
    delta  = target - int'(setpoint);
    if (delta > STEP)       sp_i = int'(setpoint) + STEP;
    else if (delta < -STEP) sp_i = int'(setpoint) - STEP;
    else                    sp_i = target;
    setpoint_next = RPM_RESOLUTION'(sp_i);
    duty_sum      = int'(duty) + int'(duty_offset);
    duty_clamped  = uclamp(duty_sum, PWM_RESOLUTION);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      setpoint <= '0;
      duty     <= '0;
      duty_sat <= 1'b0;
    end else if (clear) begin
      setpoint <= '0;
      duty     <= '0;
      duty_sat <= 1'b0;
    end else if (tick) begin
      setpoint <= setpoint_next;
      duty     <= PWM_RESOLUTION'(duty_clamped);
      duty_sat <= (duty_clamped != duty_sum);
    end
  end

endmodule

// File: rtl/motor_control_nch.sv
// N-channel motor control stage: run/stop FSM plus per-channel setpoint/duty logic.
// Define MOTOR_CONTROL_RAMP_EN to enable setpoint slew limiting.
module motor_control_nch
  import motor_control_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int PWM_RESOLUTION = 16,
  parameter int RPM_RESOLUTION = 10,
  parameter int MAX_RPM_OFFSET = 50,
  parameter int MAX_RPM        = 2**RPM_RESOLUTION - 1,
  parameter int RAMP_STEP      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clk_en,
  input  logic                               enable,
  input  logic                               estop,
  input  logic [RPM_RESOLUTION-1:0]          base_rpm,
  input  logic [N_CH*(RPM_RESOLUTION+1)-1:0] rpm_offset,
  input  logic [N_CH*(PWM_RESOLUTION+1)-1:0] duty_cycle_offset,
  output logic [N_CH*RPM_RESOLUTION-1:0]     rpm_setpoint,
  output logic [N_CH*PWM_RESOLUTION-1:0]     duty_cycle,
  output logic [N_CH-1:0]                    duty_sat,
  output logic [STATE_W-1:0]                 state
);

  state_t          state_reg, state_next;
  logic [N_CH-1:0] sp_zero;
  logic            ch_clear;

  // STOP exits once every channel's next setpoint has reached zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable) state_next = ST_RUN;
      ST_RUN:  if (!enable) state_next = ST_STOP;
      ST_STOP: begin
        if (enable)        state_next = ST_RUN;
        else if (&sp_zero) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ch_clear = estop | (clk_en & (state_next == ST_IDLE));
  assign state    = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state_reg <= ST_IDLE;
    else if (estop)  state_reg <= ST_IDLE;
    else if (clk_en) state_reg <= state_next;
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [RPM_RESOLUTION-1:0] sp_next;

    motor_channel #(
      .PWM_RESOLUTION(PWM_RESOLUTION),
      .RPM_RESOLUTION(RPM_RESOLUTION),
      .MAX_RPM_OFFSET(MAX_RPM_OFFSET),
      .MAX_RPM       (MAX_RPM),
      .RAMP_STEP     (RAMP_STEP)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (clk_en),
      .clear        (ch_clear),
      .run          (enable),
      .base_rpm     (base_rpm),
      .rpm_offset   (rpm_offset[gi*(RPM_RESOLUTION+1) +: RPM_RESOLUTION+1]),
      .duty_offset  (duty_cycle_offset[gi*(PWM_RESOLUTION+1) +: PWM_RESOLUTION+1]),
      .setpoint_next(sp_next),
      .setpoint     (rpm_setpoint[gi*RPM_RESOLUTION +: RPM_RESOLUTION]),
      .duty         (duty_cycle[gi*PWM_RESOLUTION +: PWM_RESOLUTION]),
      .duty_sat     (duty_sat[gi])
    );

    assign sp_zero[gi] = (sp_next == '0);
  end

endmodule

// File: tb/tb_motor_control_nch.sv
// Self-checking bench for motor_control_nch against a behavioural channel model.
`timescale 1ns/1ps
module tb_motor_control_nch;
  localparam int N_CH    = 2;
  localparam int PW      = 16;
  localparam int RW      = 10;
  localparam int MAX_OFF = 50;
  localparam int MAX_RPM = (1 << RW) - 1;
  localparam int MAX_DTY = (1 << PW) - 1;
  localparam int STEP    = 4;
`ifdef MOTOR_CONTROL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, clk_en, enable, estop;
  logic [RW-1:0]            base_rpm;
  logic [N_CH*(RW+1)-1:0]   rpm_offset;
  logic [N_CH*(PW+1)-1:0]   duty_cycle_offset;
  logic [N_CH*RW-1:0]       rpm_setpoint;
  logic [N_CH*PW-1:0]       duty_cycle;
  logic [N_CH-1:0]          duty_sat;
  logic [1:0]               state;

  int base;
  int off [N_CH];
  int doff[N_CH];
  int m_sp[N_CH], m_duty[N_CH], m_sat[N_CH], m_state;
  int checks = 0;
  int errors = 0;

  motor_control_nch #(.N_CH(N_CH), .PWM_RESOLUTION(PW), .RPM_RESOLUTION(RW),
                      .MAX_RPM_OFFSET(MAX_OFF), .RAMP_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .enable(enable), .estop(estop),
    .base_rpm(base_rpm), .rpm_offset(rpm_offset), .duty_cycle_offset(duty_cycle_offset),
    .rpm_setpoint(rpm_setpoint), .duty_cycle(duty_cycle), .duty_sat(duty_sat), .state(state));

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [31:0] sp_of(input int c);
    return 32'(rpm_setpoint[c*RW +: RW]);
  endfunction

  function automatic logic [31:0] duty_of(input int c);
    return 32'(duty_cycle[c*PW +: PW]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_state = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_sp[c] = 0; m_duty[c] = 0; m_sat[c] = 0;
    end
  endtask

  // Behaviour of one clock edge, from the current inputs and model state.
  task automatic model_edge();
    int nsp[N_CH];
    int tgt, nxt, s;
    bit all0;
    if (estop) begin model_zero(); return; end
    if (!clk_en) return;
    all0 = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      tgt = enable ? clampi(base + clampi(off[c], -MAX_OFF, MAX_OFF), 0, MAX_RPM) : 0;
      if (!RAMP || (tgt - m_sp[c] <= STEP && m_sp[c] - tgt <= STEP)) nsp[c] = tgt;
      else if (tgt > m_sp[c]) nsp[c] = m_sp[c] + STEP;
      else nsp[c] = m_sp[c] - STEP;
      if (nsp[c] != 0) all0 = 1'b0;
    end
    case (m_state)
      0:       nxt = enable ? 1 : 0;
      1:       nxt = enable ? 1 : 2;
      default: nxt = enable ? 1 : ((!RAMP || all0) ? 0 : 2);
    endcase
    m_state = nxt;
    for (int c = 0; c < N_CH; c++) begin
      if (nxt == 0) begin
        m_sp[c] = 0; m_duty[c] = 0; m_sat[c] = 0;
      end else begin
        m_sp[c]   = nsp[c];
        s         = m_duty[c] + doff[c];
        m_duty[c] = clampi(s, 0, MAX_DTY);
        m_sat[c]  = (m_duty[c] != s) ? 1 : 0;
      end
    end
  endtask

  task automatic drive();
    base_rpm = RW'(base);
    for (int c = 0; c < N_CH; c++) begin
      rpm_offset[c*(RW+1) +: (RW+1)]        = (RW+1)'(off[c]);
      duty_cycle_offset[c*(PW+1) +: (PW+1)] = (PW+1)'(doff[c]);
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.state", tag), 32'(state), m_state);
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("%s.sp%0d", tag, c), sp_of(c), m_sp[c]);
      chk($sformatf("%s.duty%0d", tag, c), duty_of(c), m_duty[c]);
      chk($sformatf("%s.sat%0d", tag, c), 32'(duty_sat[c]), m_sat[c]);
    end
  endtask

  task automatic cycle(input string tag);
    drive();
    model_edge();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic set_ch(input int b, input int o0, input int o1, input int d0, input int d1);
    base = b; off[0] = o0; off[1] = o1; doff[0] = d0; doff[1] = d1;
  endtask

  initial begin
    int t0, t1, t_idle;
    int dseq[5] = '{65530, 100, -65525, -50, 5};
    int dexp[5] = '{65530, 65535, 10, 0, 5};
    int sexp[5] = '{0, 1, 0, 1, 0};

    reset = 1'b1; clk_en = 1'b0; enable = 1'b0; estop = 1'b0;
    set_ch(0, 0, 0, 0, 0);
    drive();
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Ramp-up from IDLE
    set_ch(150, 20, -20, 0, 0);
    enable = 1'b1; clk_en = 1'b1;
    t0 = 0; t1 = 0;
    for (int t = 1; t <= 45; t++) begin
      cycle("ramp");
      if (t0 == 0 && sp_of(0) == 170) t0 = t;
      if (t1 == 0 && sp_of(1) == 130) t1 = t;
    end
    chk("ramp_ticks_ch0", t0, RAMP ? 43 : 1);
    chk("ramp_ticks_ch1", t1, RAMP ? 33 : 1);

    // Offset clamp
    set_ch(150, 80, -300, 0, 0);
    repeat (20) cycle("clamp");
    chk("clamp_sp0", sp_of(0), 200);
    chk("clamp_sp1", sp_of(1), 100);

    // Duty saturation on channel 0 only
    for (int i = 0; i < 5; i++) begin
      doff[0] = dseq[i];
      cycle("duty");
      chk($sformatf("duty_step%0d", i), duty_of(0), dexp[i]);
      chk($sformatf("sat_step%0d", i), 32'(duty_sat[0]), sexp[i]);
      chk($sformatf("duty_ch1_step%0d", i), duty_of(1), 0);
    end

    // Randomised operation
    for (int i = 0; i < 300; i++) begin
      base = int'($urandom_range(0, MAX_RPM));
      for (int c = 0; c < N_CH; c++) begin
        off[c]  = int'($urandom_range(0, 600)) - 300;
        doff[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 131071)) - 65536
                                              : int'($urandom_range(0, 4000)) - 2000;
      end
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      estop = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    estop = 1'b0;

    // Controlled stop from steady state
    estop = 1'b1; cycle("pre_stop_estop"); estop = 1'b0;
    set_ch(150, 20, -20, 300, 7);
    enable = 1'b1; clk_en = 1'b1;
    repeat (50) cycle("steady");
    chk("steady_sp0", sp_of(0), 170);
    enable = 1'b0;
    t_idle = 0;
    for (int t = 1; t <= 60 && t_idle == 0; t++) begin
      cycle("stop");
      if (state == 2'd0) t_idle = t;
    end
    chk("stop_ticks", t_idle, RAMP ? 43 : 2);
    chk("stop_duty0", duty_of(0), 0);

    // E-stop mid-ramp while clk_en is low, then held with enable high
    set_ch(150, 0, 0, 11, 3);
    enable = 1'b1;
    repeat (10) cycle("pre_estop");
    clk_en = 1'b0; estop = 1'b1;
    cycle("estop");
    chk("estop_state", 32'(state), 0);
    chk("estop_sp0", sp_of(0), 0);
    clk_en = 1'b1;
    repeat (5) cycle("estop_hold");
    estop = 1'b0;

    // Enable falling together with estop
    repeat (6) cycle("pre_tie");
    enable = 1'b0; estop = 1'b1;
    cycle("tie");
    chk("tie_state", 32'(state), 0);
    estop = 1'b0; enable = 1'b1;

    // clk_en gating: outputs hold while offsets keep changing
    repeat (20) cycle("pre_gate");
    clk_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_ch(int'($urandom_range(0, MAX_RPM)), int'($urandom_range(0, 100)) - 50,
             int'($urandom_range(0, 100)) - 50, int'($urandom_range(0, 2000)) - 1000, 500);
      cycle("gate");
    end
    clk_en = 1'b1;
    repeat (5) cycle("post_gate");

    // Asynchronous reset in the middle of a cycle
    #2 reset = 1'b1;
    #1;
    model_zero();
    check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_hold");
    reset = 1'b0;
    repeat (8) cycle("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
